// File: rtl/vctr_fifo_sched.sv
// vctr_fifo_sched: round-robin job scheduler in front of one shared
// vctr_fifo_full vector engine. A granted requester streams two BANDS-word
// vectors into the engine. The result vector is then drained back to the
// granted requester one word at a time.
//
// Optional feature macro: VCTR_SCHED_FIXED_PRIO_EN. When it is defined, ARB
// always picks the lowest requesting index and there is no round-robin
// pointer. When it is undefined (the default), ARB uses round-robin.
//
// Handshake semantics (all valid/ready pairs on this block): a word moves on
// a rising clk edge exactly when valid and ready are both 1 in the cycle
// before that edge. Valid may not depend on ready, and ready may depend on
// valid. Once the block asserts res_valid, res_valid and res_data/res_last/
// res_id hold until they are accepted.
module vctr_fifo_sched #(
  parameter int DATA_WIDTH      = 16,
  parameter int HSP_BANDS_WIDTH = 3,
  parameter int NUM_REQ         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          res_valid,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          res_last,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  input  logic                          res_ready,
  output logic                          eng_start,
  output logic                          eng_data_in_en,
  output logic [DATA_WIDTH-1:0]         eng_data_in,
  output logic                          eng_data_out_en,
  input  logic [DATA_WIDTH-1:0]         eng_data_out,
  input  logic                          eng_idle,
  input  logic                          eng_ready,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int BANDS = 2 ** HSP_BANDS_WIDTH;
  localparam int CW    = HSP_BANDS_WIDTH + 1;

  localparam logic [CW:0]   LOAD_WORDS = (CW + 1)'(2 * BANDS);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(2 * BANDS - 1);
  localparam logic [CW-1:0] DRAIN_END  = CW'(BANDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  logic [2:0]            state;
  logic [CW-1:0]         load_cnt;
  // Counts engine reads issued. When a word is captured, this count already
  // includes that word, so the last word is captured when it equals BANDS.
  logic [CW-1:0]         drain_cnt;
  logic                  rd_pend;
`ifdef VCTR_SCHED_FIXED_PRIO_EN
`else
  logic [IDW-1:0]        rr_ptr;
`endif

  int                    arb_base;
  logic                  arb_hit;
  logic [IDW-1:0]        arb_idx;
  logic [IDW-1:0]        arb_try;
  logic [NUM_REQ-1:0]    arb_onehot;
  logic                  load_ok;
  logic                  in_acc;
  logic                  res_acc;
  logic                  rd_issue;
  logic [DATA_WIDTH-1:0] g_data;

  // Find the first requester at or after the base index, wrapping around.
  always_comb begin
`ifdef VCTR_SCHED_FIXED_PRIO_EN
    arb_base = 0;
`else
    arb_base = int'(rr_ptr);
`endif
    arb_hit    = 1'b0;
    arb_idx    = '0;
    arb_try    = '0;
    arb_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_try = IDW'((arb_base + k) % NUM_REQ);
      if (req[arb_try]) begin
        arb_hit = 1'b1;
        arb_idx = arb_try;
      end
    end
    arb_onehot[arb_idx] = arb_hit;
  end

  // Decode the datapath strobes from the state and the granted index.
  always_comb begin
    g_data          = in_data[int'(res_id) * DATA_WIDTH +: DATA_WIDTH];
    load_ok         = (state == S_LOAD) && eng_ready && ({1'b0, load_cnt} < LOAD_WORDS);
    in_ready        = '0;
    in_ready[res_id] = load_ok;
    in_acc          = load_ok && in_valid[res_id];
    eng_data_in_en  = in_acc;
    eng_data_in     = (state == S_LOAD) ? g_data : '0;
    res_acc         = res_valid && res_ready;
    rd_issue        = (state == S_DRAIN) && !rd_pend && (!res_valid || res_ready) &&
                      (drain_cnt < DRAIN_END);
    eng_data_out_en = rd_issue;
    eng_start       = (state == S_START);
    busy            = (state != S_IDLE);
    dbg_state       = state;
  end

  // Job FSM, counters, grant and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      drain_cnt <= '0;
      rd_pend   <= 1'b0;
      gnt       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
`ifdef VCTR_SCHED_FIXED_PRIO_EN
`else
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req && eng_idle) state <= S_ARB;
        end
        S_ARB: begin
          load_cnt  <= '0;
          drain_cnt <= '0;
          rd_pend   <= 1'b0;
          if (arb_hit) begin
            gnt    <= arb_onehot;
            res_id <= arb_idx;
            state  <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (eng_ready) state <= S_LOAD;
        end
        S_LOAD: begin
          if (in_acc) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LOAD_LAST) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_done) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (rd_issue) begin
            drain_cnt <= drain_cnt + 1'b1;
            rd_pend   <= 1'b1;
          end
          // Engine output is valid one cycle after the read strobe.
          if (rd_pend) begin
            rd_pend   <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= eng_data_out;
            res_last  <= (drain_cnt == DRAIN_END);
          end else if (res_acc) begin
            res_valid <= 1'b0;
          end
          if (res_acc && res_last) begin
            gnt   <= '0;
            state <= S_RELEASE;
`ifdef VCTR_SCHED_FIXED_PRIO_EN
`else
            rr_ptr <= (res_id == IDW'(NUM_REQ - 1)) ? '0 : res_id + 1'b1;
`endif
          end
        end
        S_RELEASE: begin
          if (eng_idle) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vctr_fifo_sched.sv
// Testbench for vctr_fifo_sched with a behavioural vector-add engine.
// It runs directed scenarios and then randomized jobs. A scoreboard holds
// the expected results, and a simple grant-order model predicts each grant.
// VCTR_SCHED_FIXED_PRIO_EN switches the grant model to fixed priority.
module tb_vctr_fifo_sched;

  localparam int DW    = 16;
  localparam int HBW   = 3;
  localparam int NR    = 2;
  localparam int BANDS = 8;
  localparam int WORDS = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NR-1:0]    req, gnt, in_valid, in_ready;
  logic [NR*DW-1:0] in_data;
  logic             res_valid, res_last, res_ready;
  logic [DW-1:0]    res_data;
  logic [0:0]       res_id;
  logic             eng_start, eng_data_in_en, eng_data_out_en;
  logic [DW-1:0]    eng_data_in, eng_data_out;
  logic             eng_idle, eng_ready, eng_done, busy;
  logic [2:0]       dbg_state;

  vctr_fifo_sched #(.DATA_WIDTH(DW), .HSP_BANDS_WIDTH(HBW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .res_id(res_id), .res_ready(res_ready),
    .eng_start(eng_start), .eng_data_in_en(eng_data_in_en), .eng_data_in(eng_data_in),
    .eng_data_out_en(eng_data_out_en), .eng_data_out(eng_data_out),
    .eng_idle(eng_idle), .eng_ready(eng_ready), .eng_done(eng_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- engine model: out[i] = v1[i] + v2[i] ----------------
  logic [DW-1:0] e_mem [WORDS];
  logic [3:0]    e_wr;
  logic [2:0]    e_rd;
  int            e_dly;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_idle <= 1'b1; eng_ready <= 1'b0; eng_done <= 1'b0;
      eng_data_out <= '0; e_wr <= '0; e_rd <= '0; e_dly <= 0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start && eng_idle) begin
        eng_idle <= 1'b0; eng_ready <= 1'b1; e_wr <= '0; e_rd <= '0;
      end
      if (eng_ready && eng_data_in_en) begin
        e_mem[e_wr] <= eng_data_in;
        e_wr <= e_wr + 4'd1;
        if (e_wr == 4'd15) begin
          eng_ready <= 1'b0;
          e_dly <= int'($urandom_range(1, 4));
        end
      end
      if (e_dly > 0) begin
        e_dly <= e_dly - 1;
        if (e_dly == 1) eng_done <= 1'b1;
      end
      if (eng_data_out_en) begin
        eng_data_out <= e_mem[{1'b0, e_rd}] + e_mem[{1'b1, e_rd}];
        e_rd <= e_rd + 3'd1;
        if (e_rd == 3'd7) eng_idle <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            exp_id_q[$];
  int            order_q[$];
  int            total = 0;
  int            bad = 0;
  int            done_cnt = 0;
  int            res_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Grant-order reference: pick from the requests seen during arbitration.
  function automatic int mdl_pick(input logic [NR-1:0] r, input int ptr);
`ifdef VCTR_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    if (ptr < 0) return -2;
`else
    for (int k = 0; k < NR; k++) if (r[(ptr + k) % NR]) return (ptr + k) % NR;
`endif
    return -1;
  endfunction

  // ---------------- requester driver ----------------
  logic [DW-1:0] job_w [NR][WORDS];
  int            widx [NR];
  logic [NR-1:0] acc;
  int            stall_mode = 0;
  int            res_mode = 0;
  int            cyc = 0;
  logic [DW-1:0] s;

  initial begin
    in_valid = '0; in_data = '0; res_ready = 1'b1;
    for (int i = 0; i < NR; i++) widx[i] = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (!rst_n) widx[i] = 0;
        else if (acc[i]) begin
          widx[i]++;
          if (widx[i] == WORDS) begin
            for (int k = 0; k < BANDS; k++) begin
              s = job_w[i][k] + job_w[i][k + BANDS];
              exp_q.push_back(s);
              exp_last_q.push_back(k == BANDS - 1);
              exp_id_q.push_back(i);
            end
            for (int k = 0; k < WORDS; k++) job_w[i][k] = DW'($urandom);
            widx[i] = 0;
          end
        end
        case (stall_mode)
          0:       in_valid[i] = 1'b1;
          1:       in_valid[i] = (cyc % 3 == 0);
          default: in_valid[i] = 1'($urandom_range(0, 1));
        endcase
        in_data[i*DW +: DW] = job_w[i][widx[i]];
      end
      case (res_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'b0;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NR-1:0] req_d, gnt_d;
  logic          hold_d;
  logic [DW-1:0] hold_data;
  int            mdl_ptr, e_idx, job_in, job_out, job_res;
  logic [DW-1:0] ed;
  logic          el;
  int            ei;

  initial begin
    req_d = '0; gnt_d = '0; hold_d = 1'b0; hold_data = '0; acc = '0;
    mdl_ptr = 0; job_in = 0; job_out = 0; job_res = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_d = req; gnt_d = '0; hold_d = 1'b0; acc = '0;
        mdl_ptr = 0; job_in = 0; job_out = 0; job_res = 0;
        continue;
      end
      acc = in_valid & in_ready;
      check("in_ready_only_granted", 32'(in_ready & ~gnt), 32'd0);
      if (gnt_d == '0 && gnt != '0) begin
        e_idx = mdl_pick(req_d, mdl_ptr);
        check("grant_onehot", 32'(gnt), 32'(1) << e_idx);
        check("grant_res_id", 32'(res_id), 32'(e_idx));
        order_q.push_back(e_idx);
        mdl_ptr = (e_idx + 1) % NR;
        job_in = 0; job_out = 0; job_res = 0;
      end
      if (eng_data_in_en) job_in++;
      if (eng_data_out_en) job_out++;
      if (hold_d) begin
        check("res_hold_valid", 32'(res_valid), 32'd1);
        check("res_hold_data", 32'(res_data), 32'(hold_data));
      end
      if (res_valid && !res_ready) check("no_read_while_stalled", 32'(eng_data_out_en), 32'd0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 32'd1, 32'd0);
        else begin
          ed = exp_q.pop_front(); el = exp_last_q.pop_front(); ei = exp_id_q.pop_front();
          check("res_data", 32'(res_data), 32'(ed));
          check("res_last", 32'(res_last), 32'(el));
          check("res_id", 32'(res_id), 32'(ei));
          job_res++; res_seen++;
          if (el) begin
            check("job_in_words", 32'(job_in), 32'(WORDS));
            check("job_out_reads", 32'(job_out), 32'(BANDS));
            check("job_results", 32'(job_res), 32'(BANDS));
            done_cnt++;
          end
        end
      end
      hold_d = res_valid && !res_ready;
      hold_data = res_data;
      gnt_d = gnt;
      req_d = req;
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_gnt"}, 32'(gnt), 32'd0);
    check({p, "_in_ready"}, 32'(in_ready), 32'd0);
    check({p, "_res_valid"}, 32'(res_valid), 32'd0);
    check({p, "_res_data"}, 32'(res_data), 32'd0);
    check({p, "_res_last"}, 32'(res_last), 32'd0);
    check({p, "_res_id"}, 32'(res_id), 32'd0);
    check({p, "_eng_start"}, 32'(eng_start), 32'd0);
    check({p, "_eng_data_in_en"}, 32'(eng_data_in_en), 32'd0);
    check({p, "_eng_data_in"}, 32'(eng_data_in), 32'd0);
    check({p, "_eng_data_out_en"}, 32'(eng_data_out_en), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset(input string p);
    step(); rst_n = 1'b0;
    step(); step();
    check_reset_outputs(p);
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 800) begin step(); n++; end
    if (done_cnt < target) check({tag, "_job_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == '0 && n < 200) begin step(); n++; end
    if (gnt == '0) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (busy) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  int exp_order[3];
  int base;

  initial begin
    rst_n = 1'b0; req = '0;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < WORDS; k++) job_w[i][k] = DW'($urandom);
    for (int k = 0; k < WORDS; k++) job_w[0][k] = DW'(k + 1);
    apply_reset("rst");

    // Single requester: words 1..16 give results 10,12,...,24.
    req = 2'b01;
    step(); check("gnt_latency_1cyc", 32'(gnt), 32'd0);
    step(); check("gnt_latency_2cyc", 32'(gnt), 32'd1);
    check("busy_in_job", 32'(busy), 32'd1);
    req = 2'b00;
    wait_done(1, "single");
    step(); step(); step();
    check("gnt_dropped", 32'(gnt), 32'd0);
    check("idle_after_job", 32'(busy), 32'd0);

    // Contention over three jobs from reset.
    apply_reset("rst2");
    order_q.delete();
    base = done_cnt;
    req = 2'b11;
    wait_done(base + 3, "contention");
    req = 2'b00;
    wait_idle("contention");
`ifdef VCTR_SCHED_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
`endif
    check("order_count", 32'(order_q.size()), 32'd3);
    for (int j = 0; j < 3 && j < order_q.size(); j++)
      check($sformatf("order_%0d", j), 32'(order_q[j]), 32'(exp_order[j]));

    // Input stalls: valid 1 cycle in 3.
    stall_mode = 1;
    req = 2'b10;
    wait_gnt("stall");
    req = 2'b00;
    wait_done(done_cnt + 1, "stall");
    stall_mode = 0;
    wait_idle("stall");

    // Result backpressure mid-drain.
    base = res_seen;
    req = 2'b01;
    wait_gnt("bp");
    req = 2'b00;
    for (int n = 0; n < 300 && res_seen < base + 3; n++) step();
    check("bp_reached_mid_drain", 32'(res_seen >= base + 3), 32'd1);
    res_mode = 1;
    repeat (5) step();
    res_mode = 0;
    wait_done(done_cnt + 1, "bp");
    wait_idle("bp");

    // Reset in the middle of the load phase.
    req = 2'b01;
    for (int n = 0; n < 200 && widx[0] != 5; n++) step();
    check("midrst_reached_5_words", 32'(widx[0]), 32'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    wait_done(done_cnt + 1, "after_midrst");
    req = 2'b00;
    wait_idle("after_midrst");

    // Randomized jobs.
    stall_mode = 2;
    res_mode = 2;
    for (int j = 0; j < 8; j++) begin
      req = NR'($urandom_range(1, 3));
      wait_gnt("rand");
      if ($urandom_range(0, 1) == 1) req = NR'($urandom_range(0, 3));
      wait_done(done_cnt + 1, "rand");
    end
    req = 2'b00;
    res_mode = 0;
    stall_mode = 0;
    wait_idle("rand");
    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on the whole run.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
